// File: rtl/jram_pkg.sv
// jram shared types and constants.
// Sequencer state encoding, default geometry and a depth helper.
package jram_pkg;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_CLEAR
  } seq_e;

  localparam int JRAM_WIDTH = 8;
  localparam int JRAM_ABITS = 8;

  function automatic int jram_depth(input int abits);
    return 1 << abits;
  endfunction

endpackage

// File: rtl/jram_jmar.sv
// jmar: memory address register for jram.
// Load beats increment; hold freezes it; reset clears it.
module jmar
  import jram_pkg::*;
#(
  parameter int ABITS = JRAM_ABITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             ld_i,
  input  logic             inc_i,
  input  logic [ABITS-1:0] d_i,
  output logic [ABITS-1:0] mar_o
);

  logic [ABITS-1:0] mar_q;
  logic [ABITS-1:0] mar_d;

  // next address: load, else increment (wraps), else hold
  always_comb begin
    mar_d = mar_q;
    if (!hold_i) begin
      if (ld_i) begin
        mar_d = d_i;
      end else if (inc_i) begin
        mar_d = mar_q + 1'b1;
      end
    end
  end

  // address register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mar_q <= '0;
    end else begin
      mar_q <= mar_d;
    end
  end

  assign mar_o = mar_q;

endmodule

// File: rtl/jram.sv
// jram: clocked RAM with auto-increment MAR and bus-style strobes.
// Define JRAM_CLEAR_EN to build the bulk-clear sequencer.
module jram
  import jram_pkg::*;
#(
  parameter int WIDTH = JRAM_WIDTH,
  parameter int ABITS = JRAM_ABITS
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] bis,
  input  logic             wsa,
  input  logic             winc,
  input  logic             ws,
  input  logic             we,
  output logic [WIDTH-1:0] bos,
  output logic [ABITS-1:0] bmar,
  output logic             wbusy
);

  localparam int DEPTH = jram_depth(ABITS);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] mar;
  logic             busy;
  logic             mem_we;

  jmar #(
    .ABITS(ABITS)
  ) u_jmar (
    .clk_i (wclk),
    .rst_ni(wrst_n),
    .hold_i(busy),
    .ld_i  (wsa),
    .inc_i (winc),
    .d_i   (bis[ABITS-1:0]),
    .mar_o (mar)
  );

  assign mem_we = ws & ~busy & wrst_n;

`ifdef JRAM_CLEAR_EN
  seq_e             state_q;
  seq_e             state_d;
  logic [ABITS-1:0] cnt_q;
  logic [ABITS-1:0] cnt_d;
  logic             clr;

  // sequencer registers; reset always restarts a full clear
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= SEQ_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // walk every word once, then go idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEQ_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = SEQ_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == SEQ_CLEAR);
  assign clr  = busy & wrst_n;

  // array: clear port has priority, bus writes use pre-edge MAR
  always_ff @(posedge wclk) begin
    if (clr) begin
      mem_q[cnt_q] <= '0;
    end else if (mem_we) begin
      mem_q[mar] <= bis;
    end
  end
`else
  assign busy = 1'b0;

  // array: bus writes use the pre-edge MAR
  always_ff @(posedge wclk) begin
    if (mem_we) begin
      mem_q[mar] <= bis;
    end
  end
`endif

  assign bos   = (we & ~busy) ? mem_q[mar] : '0;
  assign bmar  = mar;
  assign wbusy = busy;

endmodule

// File: tb/tb_jram.sv
// Directed self-checking bench for jram.
// Honours JRAM_CLEAR_EN: second instance becomes the clear target.
module tb_jram;

  localparam int AW = 8;
  localparam int AA = 8;
`ifdef JRAM_CLEAR_EN
  localparam int BW = 8;
  localparam int BA = 4;
`else
  localparam int BW = 16;
  localparam int BA = 3;
`endif
  localparam int BD = 1 << BA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] a_bis;
  logic          a_wsa, a_winc, a_ws, a_we;
  logic [AW-1:0] a_bos;
  logic [AA-1:0] a_bmar;
  logic          a_wbusy;

  logic          b_rst_n;
  logic [BW-1:0] b_bis;
  logic          b_wsa, b_winc, b_ws, b_we;
  logic [BW-1:0] b_bos;
  logic [BA-1:0] b_bmar;
  logic          b_wbusy;

  int n_chk  = 0;
  int n_pass = 0;

  jram #(.WIDTH(AW), .ABITS(AA)) u_a (
    .wclk(clk), .wrst_n(rst_n), .bis(a_bis),
    .wsa(a_wsa), .winc(a_winc), .ws(a_ws), .we(a_we),
    .bos(a_bos), .bmar(a_bmar), .wbusy(a_wbusy)
  );

  jram #(.WIDTH(BW), .ABITS(BA)) u_b (
    .wclk(clk), .wrst_n(b_rst_n), .bis(b_bis),
    .wsa(b_wsa), .winc(b_winc), .ws(b_ws), .we(b_we),
    .bos(b_bos), .bmar(b_bmar), .wbusy(b_wbusy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [AW-1:0] v);
    a_wsa = 1'b1; a_bis = v;
    step();
    a_wsa = 1'b0;
  endtask

  task automatic a_write(input logic [AW-1:0] v);
    a_ws = 1'b1; a_bis = v;
    step();
    a_ws = 1'b0;
  endtask

  task automatic b_load(input logic [BW-1:0] v);
    b_wsa = 1'b1; b_bis = v;
    step();
    b_wsa = 1'b0;
  endtask

`ifdef JRAM_CLEAR_EN
  // counts busy cycles while hammering strobes that must be ignored
  task automatic b_clear_run(input string tag);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b1;
    b_wsa = 1'b1; b_winc = 1'b1; b_ws = 1'b1; b_we = 1'b1;
    b_bis = '1;
    while (b_wbusy && n < 100) begin
      if (b_bos !== '0 || b_bmar !== '0) ok = 1'b0;
      step();
      n++;
    end
    b_wsa = 1'b0; b_winc = 1'b0; b_ws = 1'b0; b_we = 1'b0;
    chk({tag, "_cycles"}, n, BD);
    chk({tag, "_quiet"}, ok, 1);
    chk({tag, "_mar"}, b_bmar, 0);
  endtask
`endif

  initial begin
    int n;
    logic ok;
    rst_n = 1'b0; b_rst_n = 1'b0;
    a_bis = '0; a_wsa = 0; a_winc = 0; a_ws = 0; a_we = 0;
    b_bis = '0; b_wsa = 0; b_winc = 0; b_ws = 0; b_we = 0;
    step();
    step();
    chk("rst_bmar", a_bmar, 0);
    chk("rst_bos", a_bos, 0);
`ifdef JRAM_CLEAR_EN
    chk("rst_busy", a_wbusy, 1);
    chk("rst_busy_b", b_wbusy, 1);
`else
    chk("rst_busy", a_wbusy, 0);
    chk("rst_busy_b", b_wbusy, 0);
`endif
    rst_n = 1'b1; b_rst_n = 1'b1;
    n = 0;
    while ((a_wbusy || b_wbusy) && n < 400) begin
      step();
      n++;
    end
    chk("idle", {a_wbusy, b_wbusy}, 0);

    // load, write, enabled read
    a_load(8'h2A);
    chk("mar_ld", a_bmar, 8'h2A);
    a_write(8'h5C);
    a_we = 1'b1;
    #1 chk("rd_en", a_bos, 8'h5C);
    a_we = 1'b0;
    #1 chk("rd_dis", a_bos, 8'h00);

    // increment wrap, load beats increment
    a_load(8'hFF);
    a_winc = 1'b1;
    step();
    chk("inc_wrap", a_bmar, 8'h00);
    a_wsa = 1'b1; a_bis = 8'h10;
    step();
    a_wsa = 1'b0; a_winc = 1'b0;
    chk("ld_prio", a_bmar, 8'h10);

    // write together with load goes to the old address
    a_load(8'h33);
    a_write(8'hA5);
    a_load(8'h05);
    a_ws = 1'b1; a_wsa = 1'b1; a_bis = 8'h33;
    step();
    a_ws = 1'b0; a_wsa = 1'b0;
    chk("wsa_mar", a_bmar, 8'h33);
    a_we = 1'b1;
    #1 chk("wsa_new_kept", a_bos, 8'hA5);
    a_we = 1'b0;
    a_load(8'h05);
    a_we = 1'b1;
    #1 chk("wsa_old_wr", a_bos, 8'h33);
    a_we = 1'b0;

    // write together with increment
    a_ws = 1'b1; a_winc = 1'b1; a_bis = 8'h6E;
    step();
    a_ws = 1'b0; a_winc = 1'b0;
    chk("winc_mar", a_bmar, 8'h06);
    a_load(8'h05);
    a_we = 1'b1;
    #1 chk("winc_old_wr", a_bos, 8'h6E);
    a_we = 1'b0;

    // read-during-write: old word before the edge, new after
    a_load(8'h40);
    a_write(8'h11);
    a_we = 1'b1; a_ws = 1'b1; a_bis = 8'h99;
    #1 chk("rdw_before", a_bos, 8'h11);
    step();
    a_ws = 1'b0;
    chk("rdw_after", a_bos, 8'h99);
    a_we = 1'b0;

    // second geometry: top word, wrap, readback
    b_load(BW'(BD - 1));
    b_ws = 1'b1; b_bis = BW'(16'hBEEF);
    step();
    b_ws = 1'b0;
    b_winc = 1'b1;
    step();
    b_winc = 1'b0;
    chk("b_wrap", b_bmar, 0);
    b_load(BW'(BD - 1));
    b_we = 1'b1;
    #1 chk("b_readback", b_bos, BW'(16'hBEEF));
    b_we = 1'b0;
    b_load(BW'(16'hFFF9) & ~BW'(BD - 1) | BW'(1));
    chk("b_upper_ign", b_bmar, 1);

`ifdef JRAM_CLEAR_EN
    // dirty every word, then reset and watch a full clear
    for (int i = 0; i < BD; i++) begin
      b_load(BW'(i));
      b_ws = 1'b1; b_bis = BW'(8'hC0 + i);
      step();
      b_ws = 1'b0;
    end
    b_rst_n = 1'b0;
    step();
    chk("clr_rst_busy", b_wbusy, 1);
    b_rst_n = 1'b1;
    b_clear_run("clr1");

    // dirty one word, abort the clear at cycle 7, restart
    b_load(BW'(3));
    b_ws = 1'b1; b_bis = BW'(8'h5A);
    step();
    b_ws = 1'b0;
    b_rst_n = 1'b0;
    step();
    b_rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    b_rst_n = 1'b0;
    step();
    b_rst_n = 1'b1;
    b_clear_run("clr2");

    ok = 1'b1;
    for (int i = 0; i < BD; i++) begin
      b_load(BW'(i));
      b_we = 1'b1;
      #1 if (b_bos !== '0) ok = 1'b0;
      b_we = 1'b0;
    end
    chk("clr_zero", ok, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
